// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and default widths for the matrix-multiply sequencer.
// Holds the FSM state enum and the BRAM address/data width defaults.
package matmul_pkg;

    localparam int BRAM_ADDR_WIDTH_DFLT = 6;
    localparam int BRAM_DATA_WIDTH_DFLT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } matmul_state_t;

endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: unsigned multiply-accumulate for one C element.
// Wraps modulo 2**DATA_WIDTH by default; saturates when MATMUL_CTRL_SAT_EN is defined.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = BRAM_DATA_WIDTH_DFLT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mac_en,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] acc
);

    localparam int W = DATA_WIDTH;

    logic [2*W-1:0] prod_full;
    logic [W-1:0]   base;
    logic [W-1:0]   prod;
    logic [W-1:0]   sum;
`ifdef MATMUL_CTRL_SAT_EN
    logic           carry;
`else
    logic           unused_hi;
`endif

    // Full-width product, then clip to W bits and add to the (possibly cleared) accumulator
    always_comb begin
        prod_full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        base      = clear ? '0 : acc;
`ifdef MATMUL_CTRL_SAT_EN
        prod        = (|prod_full[2*W-1:W]) ? '1 : prod_full[W-1:0];
        {carry, sum} = {1'b0, base} + {1'b0, prod};
        if (carry) begin
            sum = '1;
        end
`else
        unused_hi = ^prod_full[2*W-1:W];
        prod      = prod_full[W-1:0];
        sum       = base + prod;
`endif
    end

    // Accumulator only advances during MAC cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
        end else if (mac_en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: walks i/j/k over an N x N product, drives A/B reads, writes C.
// Saturating arithmetic is selected in matmul_mac via MATMUL_CTRL_SAT_EN.
module matmul_ctrl
    import matmul_pkg::*;
#(
    parameter int N               = 8,
    parameter int BRAM_ADDR_WIDTH = BRAM_ADDR_WIDTH_DFLT,
    parameter int BRAM_DATA_WIDTH = BRAM_DATA_WIDTH_DFLT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [BRAM_ADDR_WIDTH-1:0] a_rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] a_dout,
    output logic [BRAM_ADDR_WIDTH-1:0] b_rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] b_dout,
    output logic [BRAM_ADDR_WIDTH-1:0] c_wr_addr,
    output logic                       c_wr_en,
    output logic [BRAM_DATA_WIDTH-1:0] c_din
);

    localparam int AW = BRAM_ADDR_WIDTH;
    localparam logic [AW-1:0] NL   = AW'(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    matmul_state_t state;
    matmul_state_t state_nxt;

    logic [AW-1:0] i;
    logic [AW-1:0] j;
    logic [AW-1:0] k;

    logic                       mac_en;
    logic [BRAM_DATA_WIDTH-1:0] acc;

    assign mac_en = (state == MAC);

    matmul_mac #(
        .DATA_WIDTH(BRAM_DATA_WIDTH)
    ) u_mac (
        .clock (clock),
        .reset (reset),
        .mac_en(mac_en),
        .clear (k == '0),
        .a     (a_dout),
        .b     (b_dout),
        .acc   (acc)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and all outputs; the C strobe is masked by reset so an abort drops the write
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        a_rd_addr = '0;
        b_rd_addr = '0;
        c_wr_addr = '0;
        c_wr_en   = 1'b0;
        c_din     = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MAC;
                end
            end
            MAC: begin
                a_rd_addr = i * NL + k;
                b_rd_addr = k * NL + j;
                if (k == LAST) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                c_wr_en   = !reset;
                c_wr_addr = i * NL + j;
                c_din     = acc;
                if (i == LAST && j == LAST) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = MAC;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Index counters: k sweeps the dot product, j then i advance after each write
    always_ff @(posedge clock) begin
        if (reset) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                MAC: begin
                    if (k != LAST) begin
                        k <= k + 1'b1;
                    end
                end
                WRITE: begin
                    k <= '0;
                    if (j == LAST) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb_matmul_ctrl: vector table, corner sequences and random runs with a reference model.
// Expected overflow results follow MATMUL_CTRL_SAT_EN when the bench is built with it.
module tb_matmul_ctrl;

    localparam int W  = 32;
    localparam int AW = 6;
    localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string            name;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [3:0][31:0] c;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // N=2 instance
    logic          start2 = 1'b0;
    logic          busy2, done2, c_wr_en2;
    logic [AW-1:0] a_addr2, b_addr2, c_addr2;
    logic [W-1:0]  a_dout2, b_dout2, c_din2;
    logic [W-1:0]  amem2 [64];
    logic [W-1:0]  bmem2 [64];
    assign a_dout2 = amem2[a_addr2];
    assign b_dout2 = bmem2[b_addr2];

    matmul_ctrl #(.N(2), .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(W)) dut2 (
        .clock(clock), .reset(reset), .start(start2),
        .busy(busy2), .done(done2),
        .a_rd_addr(a_addr2), .a_dout(a_dout2),
        .b_rd_addr(b_addr2), .b_dout(b_dout2),
        .c_wr_addr(c_addr2), .c_wr_en(c_wr_en2), .c_din(c_din2)
    );

    // N=1 instance
    logic          start1 = 1'b0;
    logic          busy1, done1, c_wr_en1;
    logic [AW-1:0] a_addr1, b_addr1, c_addr1;
    logic [W-1:0]  a_dout1, b_dout1, c_din1;
    logic [W-1:0]  amem1 [64];
    logic [W-1:0]  bmem1 [64];
    assign a_dout1 = amem1[a_addr1];
    assign b_dout1 = bmem1[b_addr1];

    matmul_ctrl #(.N(1), .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(W)) dut1 (
        .clock(clock), .reset(reset), .start(start1),
        .busy(busy1), .done(done1),
        .a_rd_addr(a_addr1), .a_dout(a_dout1),
        .b_rd_addr(b_addr1), .b_dout(b_dout1),
        .c_wr_addr(c_addr1), .c_wr_en(c_wr_en1), .c_din(c_din1)
    );

    // C memory write logs and done-pulse counter (BRAM write at the rising edge)
    wr_t wr_q[$];
    wr_t wr1_q[$];
    int  done_cnt2 = 0;
    always @(posedge clock) begin
        if (c_wr_en2) wr_q.push_back('{int'(c_addr2), c_din2});
        if (c_wr_en1) wr1_q.push_back('{int'(c_addr1), c_din1});
        if (done2) done_cnt2++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][31:0] mk(input logic [31:0] w0, input logic [31:0] w1,
                                            input logic [31:0] w2, input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    // Reference C[i][j] for the N=2 memories, from the arithmetic rules
    function automatic logic [31:0] ref_c(input int i, input int j);
        longint unsigned s = 0;
        longint unsigned p;
        for (int k = 0; k < 2; k++) begin
            p = 64'(amem2[i*2+k]) * 64'(bmem2[k*2+j]);
`ifdef MATMUL_CTRL_SAT_EN
            if (p > MAXV) p = MAXV;
            s = s + p;
            if (s > MAXV) s = MAXV;
`else
            s = (s + p) & MAXV;
`endif
        end
        return s[31:0];
    endfunction

    task automatic load2(input logic [3:0][31:0] a, input logic [3:0][31:0] b);
        for (int e = 0; e < 4; e++) begin
            amem2[e] = a[e];
            bmem2[e] = b[e];
        end
    endtask

    // Pulse start, then count cycles until done (bounded)
    task automatic run2(input int repulse_at, output int lat, output int nbusy);
        int cyc;
        start2 = 1'b1;
        @(posedge clock); #1;
        start2 = 1'b0;
        cyc   = 0;
        nbusy = 0;
        while (!done2 && cyc < 100) begin
            if (busy2) nbusy++;
            start2 = (cyc == repulse_at);
            @(posedge clock); #1;
            cyc++;
        end
        start2 = 1'b0;
        lat = cyc;
    endtask

    task automatic check_run2(input string name, input logic [3:0][31:0] expc, input int repulse);
        int lat, nbusy, base, d0, nw;
        base = wr_q.size();
        d0   = done_cnt2;
        run2(repulse, lat, nbusy);
        chk({name, "_latency"}, lat, 12);
        chk({name, "_busy_cycles"}, nbusy, 12);
        chk({name, "_busy_in_done"}, busy2, 1);
        @(posedge clock); #1;
        chk({name, "_idle_after_done"}, {done2, busy2}, 0);
        chk({name, "_done_pulses"}, done_cnt2 - d0, 1);
        nw = wr_q.size() - base;
        chk({name, "_write_count"}, nw, 4);
        for (int e = 0; e < 4 && e < nw; e++) begin
            chk($sformatf("%s_addr%0d", name, e), wr_q[base+e].addr, e);
            chk($sformatf("%s_c%0d", name, e), wr_q[base+e].data, expc[e]);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int          cyc, base;
        logic        hit1;
        logic [3:0][31:0] expc;

        vecs[0] = '{"identity", mk(1, 0, 0, 1), mk(5, 6, 7, 8), mk(5, 6, 7, 8)};
        vecs[1] = '{"general", mk(1, 2, 3, 4), mk(5, 6, 7, 8), mk(19, 22, 43, 50)};
        vecs[2] = '{"zero", mk(0, 0, 0, 0), mk(9, 9, 9, 9), mk(0, 0, 0, 0)};
`ifdef MATMUL_CTRL_SAT_EN
        vecs[3] = '{"prod_ovf", mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1),
                    mk(32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 2),
                    mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2)};
        vecs[4] = '{"sum_ovf", mk(32'h8000_0000, 32'h8000_0000, 0, 0),
                    mk(1, 0, 1, 0), mk(32'hFFFF_FFFF, 0, 0, 0)};
`else
        vecs[3] = '{"prod_ovf", mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1),
                    mk(32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 2),
                    mk(2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2)};
        vecs[4] = '{"sum_ovf", mk(32'h8000_0000, 32'h8000_0000, 0, 0),
                    mk(1, 0, 1, 0), mk(0, 0, 0, 0)};
`endif

        for (int e = 0; e < 64; e++) begin
            amem2[e] = '0; bmem2[e] = '0;
            amem1[e] = '0; bmem1[e] = '0;
        end

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        chk("rst_wr_en", c_wr_en2, 0);
        chk("rst_a_addr", a_addr2, 0);
        chk("rst_b_addr", b_addr2, 0);
        chk("rst_c_addr", c_addr2, 0);
        chk("rst_c_din", c_din2, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Vector table
        for (int v = 0; v < 5; v++) begin
            load2(vecs[v].a, vecs[v].b);
            check_run2(vecs[v].name, vecs[v].c, -1);
            repeat (2) @(posedge clock);
            #1;
        end

        // Start while busy
        load2(vecs[1].a, vecs[1].b);
        check_run2("start_busy", vecs[1].c, 3);
        repeat (4) @(posedge clock);
        #1;
        chk("start_busy_no_extra_done", busy2, 0);

        // Back-to-back: start in the cycle right after done
        load2(vecs[0].a, vecs[0].b);
        check_run2("b2b_first", vecs[0].c, -1);
        check_run2("b2b_second", vecs[0].c, -1);

        // Reset during the second WRITE cycle
        load2(vecs[1].a, vecs[1].b);
        base   = wr_q.size();
        start2 = 1'b1;
        @(posedge clock); #1;
        start2 = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("abort_in_write", c_wr_en2, 1);
        chk("abort_write_addr", c_addr2, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        hit1 = 1'b0;
        for (int e = base; e < wr_q.size(); e++) begin
            if (wr_q[e].addr == 1) hit1 = 1'b1;
        end
        chk("abort_no_write_addr1", hit1, 0);
        chk("abort_busy", busy2, 0);
        chk("abort_done", done2, 0);
        chk("abort_wr_en", c_wr_en2, 0);
        chk("abort_addrs", {a_addr2, b_addr2, c_addr2}, 0);
        chk("abort_c_din", c_din2, 0);
        @(posedge clock); #1;
        check_run2("after_abort", vecs[1].c, -1);

        // N=1 overflow
        amem1[0] = 32'h8000_0000;
        bmem1[0] = 32'd2;
        base   = wr1_q.size();
        start1 = 1'b1;
        @(posedge clock); #1;
        start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 50) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("n1_latency", cyc, 2);
        chk("n1_write_count", wr1_q.size() - base, 1);
        if (wr1_q.size() > base) begin
            chk("n1_addr", wr1_q[base].addr, 0);
`ifdef MATMUL_CTRL_SAT_EN
            chk("n1_c", wr1_q[base].data, 32'hFFFF_FFFF);
`else
            chk("n1_c", wr1_q[base].data, 32'h0000_0000);
`endif
        end
        @(posedge clock); #1;

        // Random matrices against the reference model
        for (int r = 0; r < 20; r++) begin
            for (int e = 0; e < 4; e++) begin
                amem2[e] = ($urandom_range(0, 1) == 1) ? $urandom() : $urandom_range(0, 15);
                bmem2[e] = ($urandom_range(0, 1) == 1) ? $urandom() : $urandom_range(0, 15);
            end
            for (int e = 0; e < 4; e++) begin
                expc[e] = ref_c(e / 2, e % 2);
            end
            check_run2($sformatf("rand%0d", r), expc, -1);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Sequencer for the matrix-multiply datapath: computes C = A × B for square N×N unsigned matrices held in three single-port-write, asynchronous-read `bram` instances, A and B read-only and C write-only. The block walks the output index space, drives read addresses into the A and B memories, and multiply-accumulates the returned words. It writes each finished element into the C memory and reports completion with a start/busy/done handshake. It sits between the top-level command logic and the three BRAMs.

## Interface
- `N`, 8: matrix dimension; N*N must be ≤ 2**BRAM_ADDR_WIDTH, N ≥ 1.
- `BRAM_ADDR_WIDTH`, 6: address width of all three BRAMs.
- `BRAM_DATA_WIDTH`, 32: element and accumulator width.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `busy`  out  1  high from the cycle after start is accepted through the DONE cycle.
- `done`  out  1  single-cycle pulse when the last C element has been written.
- `a_rd_addr`  out  BRAM_ADDR_WIDTH  A read address, row-major A[i][k] at i*N+k.
- `a_dout`  in  BRAM_DATA_WIDTH  A read data, combinational from a_rd_addr.
- `b_rd_addr`  out  BRAM_ADDR_WIDTH  B read address, B[k][j] at k*N+j.
- `b_dout`  in  BRAM_DATA_WIDTH  B read data, combinational from b_rd_addr.
- `c_wr_addr`  out  BRAM_ADDR_WIDTH  C write address, C[i][j] at i*N+j.
- `c_wr_en`  out  1  C write strobe.
- `c_din`  out  BRAM_DATA_WIDTH  C write data.

## Operation
- The state machine has four states: IDLE, MAC, WRITE and DONE. Registered counters i, j and k each range over 0..N-1.
- IDLE
  - When `start` is 1, clear i, j and k, then go to MAC.
  - All other inputs are ignored.
- MAC
  - Address drive: a_rd_addr = i*N+k and b_rd_addr = k*N+j, driven from the registered counters.
  - Accumulate: acc ← (k==0 ? 0 : acc) + a_dout*b_dout.
  - If k==N-1, go to WRITE. Otherwise k ← k+1.
- WRITE
  - Outputs: c_wr_en = 1, c_wr_addr = i*N+j, c_din = acc.
  - Counters: k ← 0. Then j ← j+1, or if j==N-1, j ← 0 and i ← i+1.
  - If i==N-1 and j==N-1, go to DONE. Otherwise return to MAC.
- DONE
  - done = 1 for exactly one cycle, then go to IDLE.
  - `start` is ignored in DONE.
- Arithmetic is unsigned throughout.
  - Products and sums are taken modulo 2**BRAM_DATA_WIDTH (truncated) unless MATMUL_CTRL_SAT_EN is defined.
  - The full product is computed at 2*BRAM_DATA_WIDTH before truncation or saturation.
- Address outputs are 0 in IDLE and DONE. c_wr_en is 1 only in WRITE. c_din and c_wr_addr are 0 outside WRITE.
- `start` asserted while busy has no effect. There is no queueing.

## Timing
- Reset values: state=IDLE, busy=0, done=0, c_wr_en=0, all addresses 0, c_din=0, acc=0, i=j=k=0.
- Reset is honoured in any state. Asserting it mid-operation aborts the multiply; the C write in that cycle is suppressed and the next cycle is IDLE.
- Each C element takes N+1 cycles: N MAC cycles followed by 1 WRITE cycle.
- Latency: if start is sampled at edge T, the first MAC cycle is T+1 and done is high in cycle T+1+N*N*(N+1). For N=2, done is high 12 cycles after the start edge.
- The cycle after DONE is IDLE, so a new start is accepted at the earliest one cycle after done.
- BRAM read data is consumed combinationally in the same cycle the address is driven; there is no read wait state.
- The C write occurs at the rising edge ending the WRITE cycle.

## Configuration
- `MATMUL_CTRL_SAT_EN`
  - Defined: both the product and the accumulation saturate to 2**BRAM_DATA_WIDTH-1. Once acc is saturated it stays saturated for that element.
  - Undefined: modulo wrap-around. Timing is identical in both builds.

## Structure
- Package `matmul_pkg` holds:
  - the state enum typedef `matmul_state_t` (IDLE, MAC, WRITE, DONE);
  - a shared `BRAM_ADDR_WIDTH` / `BRAM_DATA_WIDTH` default constant pair.
- Sub-module `matmul_mac` contains the combinational multiply with truncate/saturate plus the acc register with clear-on-k==0. It is the only place that references `MATMUL_CTRL_SAT_EN`.
- The FSM, counters and address generation live in `matmul_ctrl`.

## Test plan
- Identity: N=2, A=[[1,0],[0,1]], B=[[5,6],[7,8]], pulse start. C must read [[5,6],[7,8]]; done must be high exactly 12 cycles after the start edge; c_wr_en must pulse 4 times, at addresses 0,1,2,3 in order.
- General: N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]. C must read [[19,22],[43,50]]; busy must stay high for 12 cycles.
- Overflow: N=1, A=0x8000_0000, B=2 (W=32). Without the macro C=0x0000_0000; with `MATMUL_CTRL_SAT_EN` defined C=0xFFFF_FFFF.
- Start while busy: re-pulse start during MAC. Results and done timing must be unchanged, and exactly one done pulse must occur.
- Reset mid-operation: assert reset during the second WRITE cycle. No write may occur at address 1; outputs must equal their reset values the next cycle; a fresh start must then complete correctly.
- Back-to-back: pulse start in the cycle after done. It must be accepted, and the second run must produce the same C.
